// File: rtl/issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: functional-type codes, FSM encoding
// and the issue-payload record carried from decode to dispatch.
package pa_pkg;

  localparam int unsigned PA_DATA_W = 16;
  localparam int unsigned PA_REG_W  = 5;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned STAT_W    = 2;
  localparam int unsigned FT_W      = 2;

  typedef enum logic [FT_W-1:0] {
    FT_ARITH   = 2'd0,
    FT_LDST    = 2'd1,
    FT_BRANCH  = 2'd2,
    FT_ILLEGAL = 2'd3
  } func_type_e;

  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_HOLD_B = 1'b1;

  typedef struct packed {
    logic                 is_wb;
    logic [FT_W-1:0]      func_type;
    logic [PA_REG_W-1:0]  wb_addr;
    logic [OPC_W-1:0]     op_code;
    logic [PA_DATA_W-1:0] p_operand;
    logic [PA_DATA_W-1:0] s_operand;
    logic [STAT_W-1:0]    op_status;
  } issue_t;

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-pair input bundle and registered issue outputs of the scheduler.
interface issue_scheduler_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              flushBack_i;
  logic              validA_i, validB_i;
  logic              ready_o;
  logic              isWbA_i, isWbB_i;
  logic [1:0]        functionalTypeA_i, functionalTypeB_i;
  logic [REG_W-1:0]  wbAddressA_i, wbAddressB_i;
  logic [REG_W-1:0]  srcP_A_i, srcP_B_i, srcS_A_i, srcS_B_i;
  logic              useP_A_i, useP_B_i, useS_A_i, useS_B_i;
  logic [6:0]        opCodeA_i, opCodeB_i;
  logic [DATA_W-1:0] pOperandA_i, pOperandB_i, sOperandA_i, sOperandB_i;
  logic [1:0]        operationStatusA_i, operationStatusB_i;

  logic              enableA_o, enableB_o;
  logic              isWbA_o, isWbB_o;
  logic [1:0]        functionalTypeA_o, functionalTypeB_o;
  logic [REG_W-1:0]  wbAddressA_o, wbAddressB_o;
  logic [6:0]        opCodeA_o, opCodeB_o;
  logic [DATA_W-1:0] pOperandA_o, pOperandB_o, sOperandA_o, sOperandB_o;
  logic [1:0]        operationStatusA_o, operationStatusB_o;
  logic [CNT_W-1:0]  splitCount_o;
  logic              illegal_o;

  modport slave (
    input  flushBack_i, validA_i, validB_i, isWbA_i, isWbB_i,
           functionalTypeA_i, functionalTypeB_i, wbAddressA_i, wbAddressB_i,
           srcP_A_i, srcP_B_i, srcS_A_i, srcS_B_i,
           useP_A_i, useP_B_i, useS_A_i, useS_B_i,
           opCodeA_i, opCodeB_i, pOperandA_i, pOperandB_i, sOperandA_i, sOperandB_i,
           operationStatusA_i, operationStatusB_i,
    output ready_o, enableA_o, enableB_o, isWbA_o, isWbB_o,
           functionalTypeA_o, functionalTypeB_o, wbAddressA_o, wbAddressB_o,
           opCodeA_o, opCodeB_o, pOperandA_o, pOperandB_o, sOperandA_o, sOperandB_o,
           operationStatusA_o, operationStatusB_o, splitCount_o, illegal_o
  );

  modport master (
    output flushBack_i, validA_i, validB_i, isWbA_i, isWbB_i,
           functionalTypeA_i, functionalTypeB_i, wbAddressA_i, wbAddressB_i,
           srcP_A_i, srcP_B_i, srcS_A_i, srcS_B_i,
           useP_A_i, useP_B_i, useS_A_i, useS_B_i,
           opCodeA_i, opCodeB_i, pOperandA_i, pOperandB_i, sOperandA_i, sOperandB_i,
           operationStatusA_i, operationStatusB_i,
    input  ready_o, enableA_o, enableB_o, isWbA_o, isWbB_o,
           functionalTypeA_o, functionalTypeB_o, wbAddressA_o, wbAddressB_o,
           opCodeA_o, opCodeB_o, pOperandA_o, pOperandB_o, sOperandA_o, sOperandB_o,
           operationStatusA_o, operationStatusB_o, splitCount_o, illegal_o
  );
endinterface

// File: rtl/issue_scheduler_hazard_check.sv
// Combinational pair-conflict detection: two branches, or B reading A's destination.
module hazard_check
  import pa_pkg::*;
#(
  parameter int unsigned REG_W = PA_REG_W
) (
  input  logic             valid_a_i,
  input  logic             valid_b_i,
  input  logic [FT_W-1:0]  type_a_i,
  input  logic [FT_W-1:0]  type_b_i,
  input  logic             is_wb_a_i,
  input  logic [REG_W-1:0] wb_addr_a_i,
  input  logic             use_p_b_i,
  input  logic [REG_W-1:0] src_p_b_i,
  input  logic             use_s_b_i,
  input  logic [REG_W-1:0] src_s_b_i,
  output logic             conflict_c_o
);
  logic both_branch_c;
  logic raw_c;
  logic any_illegal_c;

  assign both_branch_c = (type_a_i == FT_BRANCH) && (type_b_i == FT_BRANCH);
  // Register 0 is an ordinary register here; no zero-register exemption.
  assign raw_c = is_wb_a_i && ((use_p_b_i && (src_p_b_i == wb_addr_a_i)) ||
                               (use_s_b_i && (src_s_b_i == wb_addr_a_i)));
  // An illegal slot never dispatches, so there is no ordering to protect.
  assign any_illegal_c = (type_a_i == FT_ILLEGAL) || (type_b_i == FT_ILLEGAL);

  assign conflict_c_o = valid_a_i && valid_b_i && !any_illegal_c && (both_branch_c || raw_c);
endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: issues a decode pair together, or splits it across two
// cycles (A then held B) on a branch pair or an A->B register dependency.
module issue_scheduler
  import pa_pkg::*;
#(
  parameter int unsigned DATA_W = PA_DATA_W,
  parameter int unsigned REG_W  = PA_REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clock_i,
  input logic              reset_i,
  issue_scheduler_if.slave bus
);
  logic [0:0]       state_q, state_d;
  issue_t           hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  issue_t           out_a_q, out_a_d, out_b_q, out_b_d;
  logic             en_a_q, en_a_d, en_b_q, en_b_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] split_cnt_q, split_cnt_d;

  issue_t pay_a_c, pay_b_c;
  logic   ill_a_c, ill_b_c, conflict_c, accept_c;
  logic   unused_src_a_c;

  // A-slot source operands never influence scheduling.
  assign unused_src_a_c = ^{bus.srcP_A_i, bus.srcS_A_i, bus.useP_A_i, bus.useS_A_i};

  assign pay_a_c = '{is_wb: bus.isWbA_i, func_type: bus.functionalTypeA_i,
                     wb_addr: PA_REG_W'(bus.wbAddressA_i), op_code: bus.opCodeA_i,
                     p_operand: PA_DATA_W'(bus.pOperandA_i), s_operand: PA_DATA_W'(bus.sOperandA_i),
                     op_status: bus.operationStatusA_i};
  assign pay_b_c = '{is_wb: bus.isWbB_i, func_type: bus.functionalTypeB_i,
                     wb_addr: PA_REG_W'(bus.wbAddressB_i), op_code: bus.opCodeB_i,
                     p_operand: PA_DATA_W'(bus.pOperandB_i), s_operand: PA_DATA_W'(bus.sOperandB_i),
                     op_status: bus.operationStatusB_i};

  assign ill_a_c  = bus.validA_i && (bus.functionalTypeA_i == FT_ILLEGAL);
  assign ill_b_c  = bus.validB_i && (bus.functionalTypeB_i == FT_ILLEGAL);
  assign accept_c = (bus.validA_i || bus.validB_i) && (state_q == ST_PAIR);

  hazard_check #(.REG_W(REG_W)) u_hazard (
    .valid_a_i   (bus.validA_i),
    .valid_b_i   (bus.validB_i),
    .type_a_i    (bus.functionalTypeA_i),
    .type_b_i    (bus.functionalTypeB_i),
    .is_wb_a_i   (bus.isWbA_i),
    .wb_addr_a_i (bus.wbAddressA_i),
    .use_p_b_i   (bus.useP_B_i),
    .src_p_b_i   (bus.srcP_B_i),
    .use_s_b_i   (bus.useS_B_i),
    .src_s_b_i   (bus.srcS_B_i),
    .conflict_c_o(conflict_c)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_PAIR;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      illegal_q   <= 1'b0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      illegal_q   <= illegal_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  // Flush beats a pending held B; HOLD_B ignores the decode pair entirely.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    illegal_d   = 1'b0;
    split_cnt_d = split_cnt_q;
    if (bus.flushBack_i) begin
      state_d    = ST_PAIR;
      hold_vld_d = 1'b0;
    end else if (state_q == ST_HOLD_B) begin
      en_b_d     = hold_vld_q;
      if (hold_vld_q) out_b_d = hold_q;
      hold_vld_d = 1'b0;
      state_d    = ST_PAIR;
    end else if (accept_c) begin
      illegal_d = ill_a_c || ill_b_c;
      if (bus.validA_i) begin
        out_a_d = pay_a_c;
        en_a_d  = !ill_a_c;
      end
      if (conflict_c) begin
        hold_d     = pay_b_c;
        hold_vld_d = 1'b1;
        state_d    = ST_HOLD_B;
        if (!(&split_cnt_q)) split_cnt_d = split_cnt_q + CNT_W'(1);
      end else if (bus.validB_i) begin
        out_b_d = pay_b_c;
        en_b_d  = !ill_b_c;
      end
    end
  end

  assign bus.ready_o            = (state_q == ST_PAIR) || bus.flushBack_i;
  assign bus.enableA_o          = en_a_q;
  assign bus.enableB_o          = en_b_q;
  assign bus.illegal_o          = illegal_q;
  assign bus.splitCount_o       = split_cnt_q;
  assign bus.isWbA_o            = out_a_q.is_wb;
  assign bus.isWbB_o            = out_b_q.is_wb;
  assign bus.functionalTypeA_o  = out_a_q.func_type;
  assign bus.functionalTypeB_o  = out_b_q.func_type;
  assign bus.wbAddressA_o       = REG_W'(out_a_q.wb_addr);
  assign bus.wbAddressB_o       = REG_W'(out_b_q.wb_addr);
  assign bus.opCodeA_o          = out_a_q.op_code;
  assign bus.opCodeB_o          = out_b_q.op_code;
  assign bus.pOperandA_o        = DATA_W'(out_a_q.p_operand);
  assign bus.pOperandB_o        = DATA_W'(out_b_q.p_operand);
  assign bus.sOperandA_o        = DATA_W'(out_a_q.s_operand);
  assign bus.sOperandB_o        = DATA_W'(out_b_q.s_operand);
  assign bus.operationStatusA_o = out_a_q.op_status;
  assign bus.operationStatusB_o = out_b_q.op_status;
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter DATA_W, 16, operand width.
REQ-002 Parameter REG_W, 5, register-address width.
REQ-003 Parameter CNT_W, 16, split-event counter width.
REQ-004 clock_i  in  1  single clock; all state updates on rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 flushBack_i  in  1  pipeline flush from branch resolution.
REQ-007 validA_i, validB_i  in  1 each  decode slot holds an instruction.
REQ-008 ready_o  out  1  scheduler accepts the current decode pair this cycle.
REQ-009 isWbA_i/B_i  in  1; functionalTypeA_i/B_i  in  2 (0 arith, 1 load-store, 2 branch, 3 illegal).
REQ-010 wbAddressA_i/B_i, srcP_A_i/B_i, srcS_A_i/B_i  in  REG_W; useP_A_i/B_i, useS_A_i/B_i  in  1  source-read flags.
REQ-011 opCodeA_i/B_i  in  7; pOperandA_i/B_i, sOperandA_i/B_i  in  DATA_W; operationStatusA_i/B_i  in  2.
REQ-012 enableA_o, enableB_o  out  1  issue strobes to instruction dispatch.
REQ-013 isWbA_o/B_o, functionalTypeA_o/B_o, wbAddressA_o/B_o, opCodeA_o/B_o, pOperandA_o/B_o, sOperandA_o/B_o, operationStatusA_o/B_o  out  widths as inputs  registered issue payload.
REQ-014 splitCount_o  out  CNT_W  saturating count of split issues; illegal_o  out  1  one-cycle pulse on illegal type accepted.

Function
REQ-015 Accept when validA_i|validB_i and ready_o; all outputs registered, issue latency exactly 1 cycle after acceptance.
REQ-016 States: PAIR (ready_o=1) and HOLD_B (ready_o=0); reset state PAIR.
REQ-017 Conflict = validA_i & validB_i & (both types ==2, OR isWbA_i & ((useP_B_i & srcP_B_i==wbAddressA_i) | (useS_B_i & srcS_B_i==wbAddressA_i))).
REQ-018 PAIR, no conflict: next cycle enableA_o=validA_i, enableB_o=validB_i with matching payloads; stay PAIR.
REQ-019 PAIR, conflict: next cycle issue A only (enableB_o=0), capture B payload into hold register, go HOLD_B, increment splitCount_o.
REQ-020 HOLD_B: next cycle issue held B on pipe B (enableA_o=0, enableB_o=1), return PAIR; decode inputs ignored.
REQ-021 Only validB_i with no validA_i: issue on pipe B, no conflict check.
REQ-022 Type 3 on a valid slot: slot accepted, its enable output 0, illegal_o pulses next cycle (one pulse even if both slots illegal); not a conflict.
REQ-023 Enable outputs are 0 in any cycle following no acceptance and no HOLD_B issue; payload outputs hold last value.
REQ-024 flushBack_i high: next cycle all enables 0, hold register invalidated, state PAIR, current decode pair discarded, ready_o=1 combinationally in that cycle; flush overrides HOLD_B.
REQ-025 splitCount_o saturates at 2^CNT_W-1; not cleared by flush.
REQ-026 wbAddress 0 compares like any other register (no zero-register exemption).

Reset
REQ-027 On reset_i low: state PAIR, hold register invalid, all enables 0, illegal_o 0, splitCount_o 0, all payload outputs 0; applied asynchronously, released synchronously to clock_i.
REQ-028 Reset asserted in HOLD_B discards held B with no issue after release.

Structure
REQ-029 Functional-type encodings, state encoding and issue-payload record type in shared package pa_pkg.
REQ-030 One sub-module natural: hazard_check (combinational conflict detection, REQ-017); hold register and FSM in top.

Verification
REQ-031 Arith A wb r3, arith B reads r4 -> next cycle enableA_o=enableB_o=1, splitCount_o=0.
REQ-032 Arith A wb r3 isWb=1, B useP srcP=r3 -> cycle1 enableA_o=1/enableB_o=0, ready_o=0; cycle2 enableB_o=1 B payload; splitCount_o=1.
REQ-033 Branch on A and B -> A branch issued, B branch one cycle later; same with isWbA_i=0 and no RAW -> still split.
REQ-034 Conflict pair then flushBack_i in HOLD_B cycle -> no B issue, enables 0, ready_o=1, state PAIR.
REQ-035 A type 3, B arith -> enableA_o=0, enableB_o=1, illegal_o single pulse.
REQ-036 Force splitCount_o to all-ones (CNT_W=2, 4 splits) -> value stays 3; reset_i low mid-HOLD_B -> all outputs 0 immediately.
